// File: rtl/nn_pkg.sv
// Shared definitions for the layer-engine parameter loader: word format,
// default FIFO sizing and the loader run-state encoding.
package nn_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 64;
  localparam int CW_DEF    = $clog2(DEPTH_DEF) + 1;

  // Q8.8 fixed point, matching the engine datapath
  localparam int Q_INT_BITS  = 8;
  localparam int Q_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } ld_state_t;

  // A zero neuron count still needs one buffered word before the engine starts.
  function automatic logic [6:0] fill_threshold(input logic [5:0] nl);
    return (nl == 6'd0) ? 7'd1 : {1'b0, nl};
  endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. The head word is read
// combinationally from storage and reads as zero while the FIFO is empty.
module nn_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Flush wins over any traffic in the same cycle.
  assign do_wr = wr_en && !full  && !flush;
  assign do_rd = rd_en && !empty && !flush;

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (do_wr && !do_rd) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_rd && !do_wr) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_param_loader.sv
// Weight/bias preloader for the layer compute engine: demuxes one tagged
// parameter stream into two FIFOs and gates the engine start on layer-1 fill.
module nn_param_loader
  import nn_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_is_bias,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          run_req,
  input  logic          flush,
  input  logic [5:0]    nl_first,
  input  logic          weight_en,
  input  logic          bias_en,
  input  logic          tot_complete,
  output logic [DW-1:0] wt_in,
  output logic [DW-1:0] bias_in,
  output logic          start,
  output logic          busy,
  output logic [CW-1:0] wt_count,
  output logic [CW-1:0] bias_count,
  output logic          underflow
);

  logic      wt_full, wt_empty;
  logic      bias_full, bias_empty;
  logic      wt_push, bias_push;
  logic      fill_done;
  logic      pop_empty;
  ld_state_t state_reg, state_next;
  logic      start_reg, start_next;
  logic      underflow_reg;

  // No pass-through: readiness depends only on the selected FIFO's fullness.
  assign s_ready   = s_is_bias ? !bias_full : !wt_full;
  assign wt_push   = s_valid && !s_is_bias && !wt_full;
  assign bias_push = s_valid &&  s_is_bias && !bias_full;

  nn_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_wt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wt_push),
    .wr_data (s_data),
    .rd_en   (weight_en),
    .rd_data (wt_in),
    .count   (wt_count),
    .full    (wt_full),
    .empty   (wt_empty)
  );

  nn_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_bias_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (bias_push),
    .wr_data (s_data),
    .rd_en   (bias_en),
    .rd_data (bias_in),
    .count   (bias_count),
    .full    (bias_full),
    .empty   (bias_empty)
  );

  assign fill_done = (32'(wt_count)   >= 32'(fill_threshold(nl_first))) &&
                     (32'(bias_count) >= 32'(fill_threshold(nl_first)));

  assign pop_empty = (weight_en && wt_empty) || (bias_en && bias_empty);

  always_comb begin
    state_next = state_reg;
    start_next = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: if (run_req) state_next = FILL;
        FILL: begin
          if (fill_done) begin
            state_next = RUN;
            start_next = 1'b1;
          end
        end
        RUN:  if (tot_complete) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
    end else if (flush) begin
      underflow_reg <= 1'b0;
    end else if (pop_empty) begin
      underflow_reg <= 1'b1;
    end
  end

  assign start     = start_reg;
  assign busy      = (state_reg != IDLE);
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed bench for nn_param_loader: stimulus pushes expected head words into
// queues, a negedge monitor pops and compares them whenever the engine pops.
module tb_nn_param_loader;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_is_bias;
  logic          s_valid;
  logic          s_ready;
  logic          run_req;
  logic          flush;
  logic [5:0]    nl_first;
  logic          weight_en;
  logic          bias_en;
  logic          tot_complete;
  logic [DW-1:0] wt_in;
  logic [DW-1:0] bias_in;
  logic          start;
  logic          busy;
  logic [CW-1:0] wt_count;
  logic [CW-1:0] bias_count;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_due = -1;
  logic [DW-1:0] exp_wt[$];
  logic [DW-1:0] exp_bias[$];

  nn_param_loader #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_is_bias    (s_is_bias),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .run_req      (run_req),
    .flush        (flush),
    .nl_first     (nl_first),
    .weight_en    (weight_en),
    .bias_en      (bias_en),
    .tot_complete (tot_complete),
    .wt_in        (wt_in),
    .bias_in      (bias_in),
    .start        (start),
    .busy         (busy),
    .wt_count     (wt_count),
    .bias_count   (bias_count),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one cycle; a word expected to be accepted becomes the
  // next expected head of its FIFO.
  task automatic send(input logic [DW-1:0] d, input logic b, input logic exp_acc);
    s_data = d;
    s_is_bias = b;
    s_valid = 1'b1;
    @(negedge clk);
    $display("push data=%h bias=%0d ready=%0d expect_ready=%0d", d, b, s_ready, exp_acc);
    check("s_ready", s_ready, exp_acc);
    if (exp_acc) begin
      if (b) exp_bias.push_back(d);
      else   exp_wt.push_back(d);
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Monitor: compare the head word on every engine pop, and the start pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (weight_en) begin
        if (exp_wt.size() > 0) begin
          $display("pop weight wt_in=%h", wt_in);
          check("wt_pop", wt_in, exp_wt.pop_front());
        end else begin
          $display("pop weight on empty wt_in=%h", wt_in);
          check("wt_empty_pop", wt_in, 0);
        end
      end
      if (bias_en) begin
        if (exp_bias.size() > 0) begin
          $display("pop bias bias_in=%h", bias_in);
          check("bias_pop", bias_in, exp_bias.pop_front());
        end else begin
          $display("pop bias on empty bias_in=%h", bias_in);
          check("bias_empty_pop", bias_in, 0);
        end
      end
      if (start || cyc == start_due) begin
        $display("start=%0d at cycle %0d", start, cyc);
        check("start", start, (cyc == start_due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_data = '0; s_is_bias = 1'b0; s_valid = 1'b0;
    run_req = 1'b0; flush = 1'b0; nl_first = 6'd3;
    weight_en = 1'b0; bias_en = 1'b0; tot_complete = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wt_count", wt_count, 0);
    check("rst_bias_count", bias_count, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_underflow", underflow, 0);
    check("rst_wt_in", wt_in, 0);
    tick();
    rst_n = 1'b1;

    // Preload gating
    tick(); run_req = 1'b1;
    tick(); run_req = 1'b0;
    @(negedge clk);
    check("fill_busy", busy, 1);
    tick();
    send(16'h0040, 1'b0, 1'b1);
    send(16'h0080, 1'b0, 1'b1);
    send(16'h00C0, 1'b0, 1'b1);
    send(16'h0001, 1'b1, 1'b1);
    send(16'h0002, 1'b1, 1'b1);
    send(16'h0003, 1'b1, 1'b1);
    start_due = cyc + 1;
    @(negedge clk);
    check("fill_wt_count", wt_count, 3);
    check("fill_bias_count", bias_count, 3);
    tick();
    tick();

    // Pop order
    weight_en = 1'b1;
    repeat (3) tick();
    weight_en = 1'b0;
    @(negedge clk);
    check("pop_wt_count", wt_count, 0);
    check("pop_underflow", underflow, 0);

    // Underflow on empty weight FIFO
    tick(); weight_en = 1'b1;
    tick(); weight_en = 1'b0;
    @(negedge clk);
    check("uf_flag", underflow, 1);
    check("uf_wt_count", wt_count, 0);
    tick();
    send(16'h0100, 1'b0, 1'b1);
    @(negedge clk);
    check("uf_sticky", underflow, 1);
    check("uf_wt_count_after_push", wt_count, 1);
    tick(); weight_en = 1'b1;
    tick(); weight_en = 1'b0;
    bias_en = 1'b1;
    repeat (3) tick();
    bias_en = 1'b0;
    @(negedge clk);
    check("bias_drained", bias_count, 0);
    tick();

    // Full / backpressure
    send(16'h0A01, 1'b0, 1'b1);
    send(16'h0A02, 1'b0, 1'b1);
    send(16'h0A03, 1'b0, 1'b1);
    send(16'h0A04, 1'b0, 1'b1);
    send(16'h0A05, 1'b0, 1'b0);
    s_is_bias = 1'b1;
    @(negedge clk);
    check("full_ready_bias", s_ready, 1);
    check("full_wt_count", wt_count, 4);
    tick();
    s_is_bias = 1'b0; s_data = 16'h0BAD; s_valid = 1'b1; weight_en = 1'b1;
    @(negedge clk);
    check("full_popush_ready", s_ready, 0);
    tick();
    s_valid = 1'b0; weight_en = 1'b0;
    @(negedge clk);
    check("full_popush_count", wt_count, 3);

    // Completion
    tick(); tot_complete = 1'b1;
    tick(); tot_complete = 1'b0;
    @(negedge clk);
    check("done_busy", busy, 0);

    // Flush with two weights buffered and push+pop in the same cycle
    tick(); weight_en = 1'b1;
    tick(); weight_en = 1'b0; run_req = 1'b1;
    tick(); run_req = 1'b0;
    @(negedge clk);
    check("pre_flush_busy", busy, 1);
    check("pre_flush_wt_count", wt_count, 2);
    tick();
    flush = 1'b1; s_valid = 1'b1; s_is_bias = 1'b0; s_data = 16'h0CCC; weight_en = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0; weight_en = 1'b0;
    exp_wt.delete();
    exp_bias.delete();
    @(negedge clk);
    check("flush_wt_count", wt_count, 0);
    check("flush_bias_count", bias_count, 0);
    check("flush_busy", busy, 0);
    check("flush_underflow", underflow, 0);
    check("flush_wt_in", wt_in, 0);

    // Async reset mid-RUN with five words buffered
    tick(); run_req = 1'b1;
    tick(); run_req = 1'b0;
    send(16'h0021, 1'b0, 1'b1);
    send(16'h0022, 1'b0, 1'b1);
    send(16'h0023, 1'b0, 1'b1);
    send(16'h0011, 1'b1, 1'b1);
    send(16'h0012, 1'b1, 1'b1);
    send(16'h0013, 1'b1, 1'b1);
    start_due = cyc + 1;
    tick(); bias_en = 1'b1;
    tick(); bias_en = 1'b0;
    @(negedge clk);
    check("prerst_wt_count", wt_count, 3);
    check("prerst_bias_count", bias_count, 2);
    check("prerst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wt_count", wt_count, 0);
    check("arst_bias_count", bias_count, 0);
    check("arst_busy", busy, 0);
    check("arst_start", start, 0);
    check("arst_underflow", underflow, 0);
    check("arst_wt_in", wt_in, 0);
    check("arst_bias_in", bias_in, 0);
    exp_wt.delete();
    exp_bias.delete();
    start_due = -1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_param_loader.md
Name: nn_param_loader

Overview:
- Upstream stage of the layer compute engine. Buffers the weight and bias words arriving on one tagged valid/ready stream into two show-ahead FIFOs.
- Presents the FIFO heads on wt_in/bias_in and pops them one word per cycle while the engine asserts weight_en/bias_en.
- Holds off the engine start pulse until the first layer's weights and biases are fully buffered.
- Tracks run state until the engine reports completion, and flags underflow.

Parameters:
- DW, 16, word width (Q-format fixed point, same as engine datapath).
- DEPTH, 64, entries per FIFO (power of two, ≥ max neurons per layer).
- CW, 7, count width = clog2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DW  parameter word from host/ROM streamer.
- s_is_bias  in  1  tag: 1 = bias word, 0 = weight word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid & s_ready.
- run_req  in  1  host request to start inference.
- flush  in  1  synchronous clear of FIFOs, errors and FSM.
- nl_first  in  6  neuron count of layer 1 (preload threshold).
- weight_en  in  1  engine pop request, weight FIFO.
- bias_en  in  1  engine pop request, bias FIFO.
- tot_complete  in  1  engine end-of-inference.
- wt_in  out  DW  weight FIFO head to engine.
- bias_in  out  DW  bias FIFO head to engine.
- start  out  1  one-cycle start pulse to engine.
- busy  out  1  FSM not IDLE.
- wt_count  out  CW  weight FIFO occupancy.
- bias_count  out  CW  bias FIFO occupancy.
- underflow  out  1  sticky: pop attempted on empty FIFO.

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, pointers 0, counts 0. start=0, busy=0, underflow=0, FSM=IDLE. wt_in/bias_in read 0.
- Reset mid-operation discards all buffered words. flush behaves identically, synchronously, and has priority over push/pop in the same cycle.
- Push:
  - s_ready = !full of the FIFO selected by s_is_bias (combinational on the tag). No pass-through: a full FIFO stays not-ready even if a pop occurs that cycle.
  - The accepted word is written at wr_ptr; count increments next edge.
- Pop (show-ahead):
  - wt_in is the head word combinationally from storage. The engine samples it on the same edge weight_en is high; the pointer advances on that edge, so the next word is visible the following cycle.
  - bias_in and bias_en work the same way.
- Empty-pop: no pointer change, head output forced to 0, underflow set (sticky until reset/flush).
- Same-cycle push+pop on one FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Counts saturate never: full/empty derive from count.
- FSM:
  - IDLE: run_req → FILL.
  - FILL: when wt_count ≥ nl_first and bias_count ≥ nl_first (nl_first=0 treated as 1) → RUN, asserting start for exactly the first RUN cycle. Streaming continues during FILL and RUN.
  - RUN: tot_complete → IDLE next edge. run_req ignored outside IDLE.
  - flush in any state → IDLE.
- busy = (state != IDLE). start is registered, glitch-free, asserted only on the FILL→RUN transition.
- Latency: an accepted word appears at the head 1 cycle after acceptance if the FIFO was empty.

Decomposition:
- Shared package nn_pkg: DW, default DEPTH, Q-format constants, FSM state enum {IDLE, FILL, RUN}.
- One sub-module: nn_sync_fifo, a show-ahead synchronous FIFO with count and async active-low reset, instantiated twice (weight, bias).
- The top level holds the tag demux, the FSM and the underflow flag.

Test Plan:
- Reset value check: rst_n pulse mid-RUN with 5 words buffered → counts 0, busy 0, start 0, underflow 0, wt_in 0 within the same cycle as reset asserts.
- Preload gating: nl_first=3, run_req, stream weights 0x0040, 0x0080, 0x00C0 then biases 0x0001, 0x0002 → no start. Third bias 0x0003 accepted → start high exactly one cycle, one cycle later.
- Pop order: weight_en high 3 cycles after start → engine samples wt_in 0x0040, 0x0080, 0x00C0 in order; wt_count 3→0; underflow stays 0.
- Underflow: weight FIFO empty, weight_en=1 for 1 cycle → wt_in=0, pointer unchanged, underflow=1 and held after more valid traffic.
- Full/backpressure: DEPTH=4, push 4 weights → s_ready=0 for s_is_bias=0 but 1 for s_is_bias=1. Simultaneous pop+push when full → push rejected, count 3.
- Completion and flush: tot_complete in RUN → IDLE, busy 0. flush with 2 weights buffered and push+pop same cycle → counts 0, FSM IDLE.
